register_file_mp: RTL
=====================

Name: register_file_mp

Overview:
Multi-port, parametrised successor to the single-write CPU register file. It provides NUM_READ independent registered read ports and NUM_WRITE write ports. It adds an optional hardwired zero register, write-to-read bypass, deterministic write-conflict priority, and per-port read-valid strobes. It sits between the decode stage (reads) and the writeback stage(s) (writes) of the datapath.

Parameters:
REG_COUNT, 8, number of architectural registers (>=2)
ADDR_SIZE, $clog2(REG_COUNT), register address width
WORD_SIZE, 16, register width in bits
NUM_READ, 2, number of read ports (1..4)
NUM_WRITE, 1, number of write ports (1..2)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary
BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address; 0 = read returns the old value

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; reset reset, clock clk
r_en  input  NUM_READ  per-port read enable
r_addr  input  NUM_READ*ADDR_SIZE  packed read addresses, port p at [p*ADDR_SIZE +: ADDR_SIZE]
r_data  output  NUM_READ*WORD_SIZE  packed registered read data, port p at [p*WORD_SIZE +: WORD_SIZE]
r_valid  output  NUM_READ  per-port pulse: r_data[p] updated this cycle
w_en  input  NUM_WRITE  per-port write enable
w_addr  input  NUM_WRITE*ADDR_SIZE  packed write addresses
w_data  input  NUM_WRITE*WORD_SIZE  packed write data
w_conflict  output  1  registered pulse: two or more enabled write ports targeted the same writable register last cycle

Behaviour:
- Reset (reset=1 at a clock edge):
  - All registers go to 0; r_data = 0; r_valid = 0; w_conflict = 0.
  - Reset overrides all reads and writes in the same cycle.
  - Reset mid-operation discards any write presented that cycle.
- Reads have one-cycle latency. If r_en[p]=1 at edge N, then after edge N, r_data[p] holds the value and r_valid[p]=1 for exactly one cycle.
- If r_en[p]=0, r_data[p] holds its previous value and r_valid[p]=0.
- Read value selection at edge N:
  - ZERO_REG=1 and r_addr[p]==0 -> 0.
  - Else if BYPASS=1 and some write port q has w_en[q]=1 and w_addr[q]==r_addr[p] -> winning w_data for that address (priority rule below).
  - Else -> stored register contents before edge N.
- Writes commit at the edge: register[w_addr[q]] <= w_data[q] when w_en[q]=1.
  - ZERO_REG=1: writes to address 0 are dropped silently; register 0 stays 0.
- Write conflict (NUM_WRITE=2, both enabled, same address):
  - The highest-index port wins, for storage and for bypass.
  - w_conflict=1 in the following cycle only.
  - A conflict on address 0 with ZERO_REG=1 does not flag.
- Addresses >= REG_COUNT (non-power-of-2 REG_COUNT):
  - Writes are dropped.
  - Reads return 0 with r_valid still pulsed.
- Multiple read ports may read the same address in the same cycle; all receive identical data.
- No combinational path from inputs to outputs; all outputs are registered.
- Read and write enables are independent. Unlike the previous generation, a read on a port never blocks or replaces a write.

Test Plan:
- Reset then read all: assert reset 1 cycle; r_en=all ones, addresses 0..NUM_READ-1 -> next cycle r_data all 0, r_valid all 1; following cycle with r_en=0 -> r_valid=0, r_data held.
- Write then read: w_en[0]=1, w_addr=3, w_data=16'hBEEF; next cycle r_en[1]=1, r_addr[1]=3 -> r_data[1]=16'hBEEF one cycle later, r_valid[1]=1.
- Bypass: same cycle w_addr=5, w_data=16'h1234, r_addr[0]=5, r_en[0]=1 -> r_data[0]=16'h1234 with BYPASS=1; with BYPASS=0, r_data[0]=previous value of reg 5 (0 after reset).
- Zero register: write 16'hFFFF to address 0, then read address 0 on all ports -> r_data=0 (ZERO_REG=1); with ZERO_REG=0 -> 16'hFFFF.
- Write conflict (NUM_WRITE=2): both ports write address 2, port0 16'hAAAA, port1 16'h5555 -> next cycle w_conflict=1, and a later read of reg 2 returns 16'h5555; same test on address 0 -> w_conflict=0.
- Reset mid-write: w_en=1, w_addr=4, w_data=16'h00FF with reset=1 in the same cycle -> subsequent read of reg 4 returns 0; r_valid=0 during the reset cycle.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ registered read ports, NUM_WRITE write ports, optional zero register and write bypass.
// Read data and valid appear one cycle after r_en; the file accepts every request, so there is no backpressure.
module register_file_mp #(
  parameter int REG_COUNT = 8,
  parameter int ADDR_SIZE = $clog2(REG_COUNT),
  parameter int WORD_SIZE = 16,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ-1:0]            r_en,
  input  logic [NUM_READ*ADDR_SIZE-1:0]  r_addr,
  output logic [NUM_READ*WORD_SIZE-1:0]  r_data,
  output logic [NUM_READ-1:0]            r_valid,
  input  logic [NUM_WRITE-1:0]           w_en,
  input  logic [NUM_WRITE*ADDR_SIZE-1:0] w_addr,
  input  logic [NUM_WRITE*WORD_SIZE-1:0] w_data,
  output logic                           w_conflict
);

  logic [WORD_SIZE-1:0]          regs_q [REG_COUNT];
  logic [WORD_SIZE-1:0]          regs_d [REG_COUNT];
  logic [NUM_READ*WORD_SIZE-1:0] r_data_q, r_data_d;
  logic [NUM_READ-1:0]           r_valid_q;
  logic                          conflict_q, conflict_d;
  logic                          seen;

  // Ports are scanned in ascending order so the highest-index writer wins.
  // Out-of-range addresses never match a register and are dropped.
  always_comb begin
    regs_d     = regs_q;
    conflict_d = 1'b0;
    seen       = 1'b0;
    for (int r = 0; r < REG_COUNT; r++) begin
      seen = 1'b0;
      for (int q = 0; q < NUM_WRITE; q++) begin
        if (w_en[q] && (w_addr[q*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r)) &&
            !(ZERO_REG != 0 && r == 0)) begin
          regs_d[r] = w_data[q*WORD_SIZE +: WORD_SIZE];
          if (seen) conflict_d = 1'b1;
          seen = 1'b1;
        end
      end
    end
  end

  // regs_d already holds the winning write data, so it doubles as the bypass source.
  always_comb begin
    r_data_d = r_data_q;
    for (int p = 0; p < NUM_READ; p++) begin
      if (r_en[p]) begin
        r_data_d[p*WORD_SIZE +: WORD_SIZE] = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
          if ((r_addr[p*ADDR_SIZE +: ADDR_SIZE] == ADDR_SIZE'(r)) &&
              !(ZERO_REG != 0 && r == 0)) begin
            r_data_d[p*WORD_SIZE +: WORD_SIZE] = (BYPASS != 0) ? regs_d[r] : regs_q[r];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      r_data_q   <= '0;
      r_valid_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      r_data_q   <= r_data_d;
      r_valid_q  <= r_en;
      conflict_q <= conflict_d;
    end
  end

  assign r_data     = r_data_q;
  assign r_valid    = r_valid_q;
  assign w_conflict = conflict_q;

endmodule
